// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge path.
package sobel_pkg;
    localparam int SOBEL_LAT = 4;
    localparam int GW        = 11;
    localparam int PW        = 8;

    // win[row][col]; row 0 is line r-2, col 0 is pixel c-2, centre is [1][1]
    typedef logic [2:0][2:0][PW-1:0] sobel_win_t;
endpackage

// File: rtl/sobel_edge_if.sv
// Pixel stream into and edge stream out of sobel_edge; master is the video source side.
interface sobel_edge_if #(parameter int DW = sobel_pkg::PW);
    logic          InHsync;
    logic          InVsync;
    logic          InPixValid;
    logic [DW-1:0] InPixData;
    logic [DW-1:0] InThresh;
    logic          OutHsync;
    logic          OutVsync;
    logic          OutPixValid;
    logic [DW-1:0] OutPixData;

    modport master (
        output InHsync, InVsync, InPixValid, InPixData, InThresh,
        input  OutHsync, OutVsync, OutPixValid, OutPixData
    );
    modport slave (
        input  InHsync, InVsync, InPixValid, InPixData, InThresh,
        output OutHsync, OutVsync, OutPixValid, OutPixData
    );
endinterface

// File: rtl/sobel_line_fifo.sv
// One-line pixel delay: single address, read-before-write, combinational read so the
// tap is usable in the same cycle the new pixel overwrites it.
module sobel_line_fifo #(
    parameter int DEPTH = 2048,
    parameter int DW    = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          InPixClk,
    input  logic          wrEn,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wrData,
    output logic [DW-1:0] rdData
);
    logic [DW-1:0] mem [DEPTH];

    assign rdData = (32'(addr) < DEPTH) ? mem[addr] : '0;

    always_ff @(posedge InPixClk) begin
        if (wrEn) mem[addr] <= wrData;
    end
endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector with a fixed 4-cycle latency on syncs, valid and data.
// Define SOBEL_THRESH_EN to emit a binary edge map (mag >= InThresh) instead of the magnitude.
module sobel_edge
    import sobel_pkg::*;
#(
    parameter int MAX_HACT = 2048,
    parameter int DW       = PW
) (
    input  logic        InPixClk,
    input  logic        InRstN,
    sobel_edge_if.slave io
);
    localparam int CW = $clog2(MAX_HACT + 1);
    localparam int AW = (MAX_HACT > 1) ? $clog2(MAX_HACT) : 1;
    localparam logic [GW-1:0] SAT = GW'((1 << DW) - 1);

    function automatic logic [GW-1:0] wsum(input logic [DW-1:0] a, b, c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    function automatic logic [GW-1:0] absv(input logic signed [GW-1:0] v);
        return v[GW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic [CW-1:0]          col;
    logic [1:0]             row;
    logic                   prevValid, seenVs;
    logic                   colOk, eol, mskIn;
    logic [1:0][DW-1:0]     lbRd;
    sobel_win_t             win;
    logic signed [GW-1:0]   gx, gy;
    logic [GW-1:0]          mag;
    logic [DW-1:0]          magSat, result, outData;
    logic [SOBEL_LAT:1]     hsPipe, vsPipe, vldPipe;
    logic [SOBEL_LAT-1:1]   mskPipe;

    assign colOk = col < CW'(MAX_HACT);
    assign eol   = prevValid && !io.InPixValid;
    // Everything that must read as zero is folded into one bit carried with the data
    assign mskIn = !io.InPixValid || !io.InVsync || !seenVs || (row != 2'd2)
                 || (col < CW'(2)) || !colOk;

    always_ff @(posedge InPixClk or negedge InRstN) begin
        if (!InRstN) begin
            col       <= '0;
            row       <= '0;
            prevValid <= 1'b0;
            seenVs    <= 1'b0;
        end else begin
            prevValid <= io.InPixValid;
            if (!io.InVsync) seenVs <= 1'b1;
            if (!io.InPixValid)  col <= '0;
            else if (colOk)      col <= col + 1'b1;
            if (!io.InVsync)                row <= '0;
            else if (eol && row != 2'd2)    row <= row + 1'b1;
        end
    end

    // lb0 holds line r-1 and feeds its old contents into lb1 (line r-2)
    for (genvar i = 0; i < 2; i++) begin : gLb
        sobel_line_fifo #(.DEPTH(MAX_HACT), .DW(DW)) uLb (
            .InPixClk (InPixClk),
            .wrEn     (io.InPixValid && colOk),
            .addr     (col[AW-1:0]),
            .wrData   ((i == 0) ? io.InPixData : lbRd[0]),
            .rdData   (lbRd[i])
        );
    end

    assign magSat = (mag > SAT) ? SAT[DW-1:0] : mag[DW-1:0];
`ifdef SOBEL_THRESH_EN
    assign result = (magSat >= io.InThresh) ? '1 : '0;
`else
    logic unusedThresh;
    assign result       = magSat;
    assign unusedThresh = ^io.InThresh;
`endif

    always_ff @(posedge InPixClk or negedge InRstN) begin
        if (!InRstN) begin
            hsPipe  <= '0;
            vsPipe  <= '0;
            vldPipe <= '0;
            mskPipe <= '0;
            win     <= '0;
            gx      <= '0;
            gy      <= '0;
            mag     <= '0;
            outData <= '0;
        end else begin
            hsPipe  <= {hsPipe[SOBEL_LAT-1:1], io.InHsync};
            vsPipe  <= {vsPipe[SOBEL_LAT-1:1], io.InVsync};
            vldPipe <= {vldPipe[SOBEL_LAT-1:1], io.InPixValid};
            mskPipe <= {mskPipe[SOBEL_LAT-2:1], mskIn};
            if (io.InPixValid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lbRd[1];
                win[1][2] <= lbRd[0];
                win[2][2] <= io.InPixData;
            end
            gx      <= $signed(wsum(win[0][2], win[1][2], win[2][2])
                             - wsum(win[0][0], win[1][0], win[2][0]));
            gy      <= $signed(wsum(win[2][0], win[2][1], win[2][2])
                             - wsum(win[0][0], win[0][1], win[0][2]));
            mag     <= absv(gx) + absv(gy);
            outData <= mskPipe[SOBEL_LAT-1] ? '0 : result;
        end
    end

    assign io.OutHsync    = hsPipe[SOBEL_LAT];
    assign io.OutVsync    = vsPipe[SOBEL_LAT];
    assign io.OutPixValid = vldPipe[SOBEL_LAT];
    assign io.OutPixData  = outData;
endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: directed frames push expected pixels, a negedge monitor checks.
module tb_sobel_edge;
    localparam int MAXH  = 16;
    localparam int DW    = 8;
    localparam int W     = 14;
    localparam int H     = 8;
    localparam int STEPC = 8;
    localparam int DR    = 4;
    localparam int DC    = 6;

    typedef enum int {FLAT, STEP, RAMP, DOT} kind_t;
    typedef struct { int r; int c; logic [7:0] v; } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    sobel_edge_if #(.DW(DW)) io ();
    sobel_edge #(.MAX_HACT(MAXH), .DW(DW)) dut (
        .InPixClk (clk),
        .InRstN   (rstN),
        .io       (io)
    );

    int   nVec = 0;
    int   nMis = 0;
    int   thr  = 8;
    bit   tbSeen = 1'b0;
    exp_t expQ[$];
    logic [2:0] hist [4];   // {hs,vs,vld} driven at the last four sampling edges

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nMis++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    function automatic logic [7:0] pixOf(kind_t k, int r, int c);
        case (k)
            FLAT:    return 8'd100;
            STEP:    return (c >= STEPC) ? 8'd255 : 8'd0;
            RAMP:    return 8'(c);
            default: return (r == DR && c == DC) ? 8'd255 : 8'd0;
        endcase
    endfunction

    // Output slot (r,c) carries the result centred on pixel (r-1,c-1)
    function automatic logic [7:0] expOf(kind_t k, int r, int c);
        if (!tbSeen || r < 2 || c < 2 || c >= MAXH) return 8'd0;
        case (k)
            FLAT: return 8'd0;
            STEP: return (c == STEPC || c == STEPC + 1) ? 8'd255 : 8'd0;
            RAMP:
`ifdef SOBEL_THRESH_EN
                return (8 >= thr) ? 8'd255 : 8'd0;
`else
                return 8'd8;
`endif
            default:
                if (r >= DR && r <= DR + 2 && c >= DC && c <= DC + 2)
                    return (r == DR + 1 && c == DC + 1) ? 8'd0 : 8'd255;
                else
                    return 8'd0;
        endcase
    endfunction

    task automatic cyc(input logic hs, input logic vs, input logic vld, input logic [7:0] pix,
                       input int r, input int c, input logic [7:0] expv);
        io.InHsync    = hs;
        io.InVsync    = vs;
        io.InPixValid = vld;
        io.InPixData  = pix;
        if (!vs) tbSeen = 1'b1;
        if (vld && rstN) expQ.push_back('{r: r, c: c, v: expv});
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        #1;
        chk("midrst_hsync", {31'd0, io.OutHsync}, 0);
        chk("midrst_vsync", {31'd0, io.OutVsync}, 0);
        chk("midrst_valid", {31'd0, io.OutPixValid}, 0);
        chk("midrst_data", {24'd0, io.OutPixData}, 0);
        expQ.delete();
        tbSeen = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic frame(input kind_t k, input int w, input int h, input int rstRow);
        // two Vsync-low lines; the second carries a stray valid burst that must read 0
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, -1, -1, 8'd0);
            for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, l == 1, 8'd77, -1, i, 8'd0);
            for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'd0, -1, -1, 8'd0);
        end
        for (int r = 0; r < h; r++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'd0, r, -1, 8'd0);
            cyc(1'b0, 1'b1, 1'b0, 8'd0, r, -1, 8'd0);
            cyc(1'b1, 1'b1, 1'b0, 8'd0, r, -1, 8'd0);
            cyc(1'b1, 1'b1, 1'b0, 8'd0, r, -1, 8'd0);
            for (int c = 0; c < w; c++) begin
                if (r == rstRow && c == w / 2) doReset();
                cyc(1'b1, 1'b1, 1'b1, pixOf(k, r, c), r, c, expOf(k, r, c));
            end
            cyc(1'b1, 1'b1, 1'b0, 8'd0, r, -1, 8'd0);
            cyc(1'b1, 1'b1, 1'b0, 8'd0, r, -1, 8'd0);
        end
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 4; i++) hist[i] <= 3'b000;
        end else begin
            hist[0] <= {io.InHsync, io.InVsync, io.InPixValid};
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("hsync_delay", {31'd0, io.OutHsync}, {31'd0, hist[3][2]});
        chk("vsync_delay", {31'd0, io.OutVsync}, {31'd0, hist[3][1]});
        chk("valid_delay", {31'd0, io.OutPixValid}, {31'd0, hist[3][0]});
        if (io.OutPixValid) begin
            if (expQ.size() == 0) begin
                chk("unexpected_valid", {31'd0, io.OutPixValid}, 0);
            end else begin
                e = expQ.pop_front();
                chk($sformatf("pix_r%0d_c%0d", e.r, e.c), {24'd0, io.OutPixData}, {24'd0, e.v});
            end
        end else begin
            chk("idle_data", {24'd0, io.OutPixData}, 0);
        end
    end

    initial begin
        io.InHsync    = 1'b1;
        io.InVsync    = 1'b1;
        io.InPixValid = 1'b0;
        io.InPixData  = 8'd0;
        io.InThresh   = 8'(thr);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hsync", {31'd0, io.OutHsync}, 0);
        chk("rst_vsync", {31'd0, io.OutVsync}, 0);
        chk("rst_valid", {31'd0, io.OutPixValid}, 0);
        chk("rst_data", {24'd0, io.OutPixData}, 0);
        rstN = 1'b1;

        frame(FLAT, W, H, -1);
        frame(STEP, W, H, -1);
        frame(DOT, W, H, -1);
        // 20-pixel lines overrun MAX_HACT=16: slots 16..19 read 0, next line unaffected
        thr = 200; io.InThresh = 8'(thr);
        frame(RAMP, 20, 6, -1);
        thr = 8;   io.InThresh = 8'(thr);
        frame(RAMP, 20, 6, -1);
        frame(STEP, W, H, 3);
        frame(STEP, W, H, -1);

        repeat (8) cyc(1'b1, 1'b1, 1'b0, 8'd0, -1, -1, 8'd0);
        chk("queue_drained", 32'(expQ.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
